// File: rtl/sram_arb_pkg.sv
// Shared definitions for the multi-port SRAM arbiter.
// Contents:
//   state_e            - controller state encoding (IDLE/SETUP/ACCESS/DONE)
//   DefaultWaitCycles  - ACCESS cycles for a 10 ns SRAM on a 50 MHz clock
//   clog2()            - index width helper, never returns less than 1
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } state_e;

    // One 20 ns cycle comfortably covers a 10 ns SRAM access.
    localparam int unsigned DefaultWaitCycles = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Ports:
//   req_i  - request vector, one bit per port
//   ptr_i  - highest-priority port index; search proceeds upward with wrap
//   en_i   - when low no grant is produced
//   gnt_o  - one-hot grant (all zero when nothing eligible or disabled)
//   idx_o  - index of the granted port (0 when no grant)
// The pointer register lives in the parent.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [clog2(NUM_PORTS)-1:0] ptr_i,
    input  logic                        en_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic [clog2(NUM_PORTS)-1:0] idx_o
);

    localparam int unsigned IdW = clog2(NUM_PORTS);

    int unsigned    cand;
    logic [IdW-1:0] cand_idx;
    logic           found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = IdW'(cand);
            if (en_i && !found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/multi_sram_arbiter.sv
// N-port arbiter and controller for an asynchronous SRAM.
// Ports:
//   iCLK, iRST          - clock, synchronous active-high reset
//   iMODE_FIXED,iSelect - 1 = serve only port iSelect, 0 = round-robin
//   iREQ, iWE           - per-port request (held until oACK) and direction
//   iADDR, iDATA, iBE   - packed per-port address, write data, byte enables
//   oACK                - one-cycle completion pulse for the served port
//   oDATA               - read data, valid with the matching oACK on reads
//   oGNT_ID             - port being or last served
//   SRAM_*              - SRAM pins; controls and byte masks active-low
// Every transaction walks IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
// All outputs come straight from flops; the next values are derived from
// the next state so the pins change on the same edge as the state.
module multi_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
    input  logic                            iCLK,
    input  logic                            iRST,
    input  logic                            iMODE_FIXED,
    input  logic [clog2(NUM_PORTS)-1:0]     iSelect,
    input  logic [NUM_PORTS-1:0]            iREQ,
    input  logic [NUM_PORTS-1:0]            iWE,
    input  logic [NUM_PORTS*ADDR_W-1:0]     iADDR,
    input  logic [NUM_PORTS*DATA_W-1:0]     iDATA,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   iBE,
    output logic [NUM_PORTS-1:0]            oACK,
    output logic [DATA_W-1:0]               oDATA,
    output logic [clog2(NUM_PORTS)-1:0]     oGNT_ID,
    inout  wire  [DATA_W-1:0]               SRAM_DQ,
    output logic [ADDR_W-1:0]               SRAM_ADDR,
    output logic                            SRAM_UB_N,
    output logic                            SRAM_LB_N,
    output logic                            SRAM_WE_N,
    output logic                            SRAM_OE_N,
    output logic                            SRAM_CE_N
);

    localparam int unsigned IdW = clog2(NUM_PORTS);
    localparam int unsigned BeW = DATA_W / 8;

    state_e              state_q, state_d;
    logic [IdW-1:0]      id_q, id_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BeW-1:0]      be_q, be_d;
    logic                we_q, we_d;
    logic [3:0]          cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ce_n_q, ce_n_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 ub_n_q, ub_n_d;
    logic                 lb_n_q, lb_n_d;
    logic                 dq_oe_q, dq_oe_d;

    logic [NUM_PORTS-1:0] req_elig;
    logic [IdW-1:0]       arb_ptr;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IdW-1:0]       arb_idx;

    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [BeW-1:0]       sel_be;
    logic                 sel_we;

    // Fixed mode reuses the arbiter with only the selected request visible.
    always_comb begin
        req_elig = iREQ;
        if (iMODE_FIXED) begin
            req_elig = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (iSelect == IdW'(p)) begin
                    req_elig[p] = iREQ[p];
                end
            end
        end
    end

    assign arb_ptr = iMODE_FIXED ? iSelect : rr_ptr_q;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .req_i (req_elig),
        .ptr_i (arb_ptr),
        .en_i  (state_q == StIdle),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Winner's request fields, picked with constant slices.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_be   = '0;
        sel_we   = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (arb_idx == IdW'(p)) begin
                sel_addr = iADDR[p*ADDR_W +: ADDR_W];
                sel_data = iDATA[p*DATA_W +: DATA_W];
                sel_be   = iBE[p*BeW +: BeW];
                sel_we   = iWE[p];
            end
        end
    end

    // Next state and latched transaction fields.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    id_d    = arb_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    be_d    = sel_be;
                    we_d    = sel_we;
                    state_d = StSetup;
                    if (!iMODE_FIXED) begin
                        if (arb_idx == IdW'(NUM_PORTS - 1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = arb_idx + 1'b1;
                        end
                    end
                end
            end
            StSetup: begin
                cnt_d   = 4'd0;
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pin values for the cycle we are about to enter.
    always_comb begin
        ce_n_d  = (state_d == StIdle);
        oe_n_d  = !(!we_d && (state_d == StSetup || state_d == StAccess));
        we_n_d  = !(we_d && state_d == StAccess);
        dq_oe_d = we_d && (state_d != StIdle);
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        if (state_d != StIdle) begin
            ub_n_d = ~be_d[BeW-1];
            lb_n_d = ~be_d[0];
        end
        ack_d = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (state_d == StDone && id_d == IdW'(p)) begin
                ack_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            id_q     <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            cnt_q    <= 4'd0;
            ack_q    <= '0;
            rdata_q  <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    assign oACK      = ack_q;
    assign oDATA     = rdata_q;
    assign oGNT_ID   = id_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;
    // data_q only changes in IDLE, so the bus is stable while driven.
    assign SRAM_DQ   = dq_oe_q ? data_q : {DATA_W{1'bz}};

endmodule
